// File: rtl/mesi_isc_nport.sv
// rtl/mesi_isc_nport.sv - N-port MESI intersection controller with round-robin broadcast queue
// Purpose: arbitrates WR_BROAD/RD_BROAD requests from NUM_CPU main-bus ports into a
// broadcast FIFO, then runs each head entry as a snoop phase to every other CPU
// followed by an enable phase to the originating CPU.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mbus_cmd_i/addr_i   per-CPU main-bus command/address, CPU i in slice i
//   cbus_ack_i          per-CPU coherence-bus acknowledge
//   mbus_ack_o          one-cycle accept pulse to the winning CPU
//   cbus_addr_o         address of the entry in service (0 when idle)
//   cbus_cmd_o          per-CPU coherence command
//   broad_id_o          sequence id of the entry in service (0 when idle)
//   fifo_count_o        broadcast FIFO occupancy
//   busy_o              engine not idle
module mesi_isc_nport #(
  parameter int NUM_CPU               = 4,
  parameter int CPU_ID_WIDTH          = 2,
  parameter int ADDR_WIDTH            = 32,
  parameter int MBUS_CMD_WIDTH        = 3,
  parameter int CBUS_CMD_WIDTH        = 3,
  parameter int BROAD_ID_WIDTH        = 5,
  parameter int BROAD_FIFO_DEPTH      = 4,
  parameter int BROAD_FIFO_DEPTH_LOG2 = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CPU*MBUS_CMD_WIDTH-1:0]  mbus_cmd_i,
  input  logic [NUM_CPU*ADDR_WIDTH-1:0]      mbus_addr_i,
  input  logic [NUM_CPU-1:0]                 cbus_ack_i,
  output logic [NUM_CPU-1:0]                 mbus_ack_o,
  output logic [ADDR_WIDTH-1:0]              cbus_addr_o,
  output logic [NUM_CPU*CBUS_CMD_WIDTH-1:0]  cbus_cmd_o,
  output logic [BROAD_ID_WIDTH-1:0]          broad_id_o,
  output logic [BROAD_FIFO_DEPTH_LOG2:0]     fifo_count_o,
  output logic                               busy_o
);

  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);
  localparam int CNT_W = BROAD_FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SNOOP, ENABLE} state_t;

  state_t                            state_q, state_d;
  logic [CPU_ID_WIDTH-1:0]           ptr_q;
  logic [BROAD_ID_WIDTH-1:0]         id_cnt_q;
  logic [BROAD_FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic [NUM_CPU-1:0]                ack_q, ack_d;
  logic [NUM_CPU-1:0]                sticky_q, sticky_d;
  logic [NUM_CPU*CBUS_CMD_WIDTH-1:0] cbus_cmd_q, cbus_cmd_d;
  logic [ADDR_WIDTH-1:0]             cbus_addr_q, cbus_addr_d;
  logic [BROAD_ID_WIDTH-1:0]         broad_id_q, broad_id_d;
  logic                              busy_q;

  logic [ADDR_WIDTH-1:0]     fifo_addr_q [BROAD_FIFO_DEPTH];
  logic                      fifo_rd_q   [BROAD_FIFO_DEPTH];  // 1 = read broadcast
  logic [CPU_ID_WIDTH-1:0]   fifo_cpu_q  [BROAD_FIFO_DEPTH];
  logic [BROAD_ID_WIDTH-1:0] fifo_id_q   [BROAD_FIFO_DEPTH];

  logic [NUM_CPU-1:0]        req;
  logic                      found, accept, pop, win_rd;
  logic [CPU_ID_WIDTH-1:0]   winner, ptr_d;
  logic [ADDR_WIDTH-1:0]     win_addr;
  logic [NUM_CPU-1:0]        origin_mask;
  logic                      head_rd;
  int                        arb_idx;

  // Round-robin search starting at ptr_q; a port acked this cycle is still
  // holding its request and must not win again.
  always_comb begin
    req      = '0;
    found    = 1'b0;
    winner   = '0;
    arb_idx  = 0;
    win_rd   = 1'b0;
    win_addr = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      req[i] = !ack_q[i] &&
               ((mbus_cmd_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == MBUS_WR_BROAD) ||
                (mbus_cmd_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == MBUS_RD_BROAD));
    end
    for (int k = 0; k < NUM_CPU; k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= NUM_CPU) arb_idx = arb_idx - NUM_CPU;
      if (!found && req[CPU_ID_WIDTH'(arb_idx)]) begin
        found  = 1'b1;
        winner = CPU_ID_WIDTH'(arb_idx);
      end
    end
    for (int i = 0; i < NUM_CPU; i++) begin
      if (CPU_ID_WIDTH'(i) == winner) begin
        win_rd   = (mbus_cmd_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == MBUS_RD_BROAD);
        win_addr = mbus_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign accept = found && (count_q != CNT_W'(BROAD_FIFO_DEPTH));
  assign ptr_d  = (winner == CPU_ID_WIDTH'(NUM_CPU - 1)) ? '0 : winner + CPU_ID_WIDTH'(1);

  always_comb begin
    origin_mask = '0;
    for (int j = 0; j < NUM_CPU; j++) begin
      origin_mask[j] = (CPU_ID_WIDTH'(j) == fifo_cpu_q[rd_ptr_q]);
    end
  end
  assign head_rd = fifo_rd_q[rd_ptr_q];
  assign pop     = (state_q == ENABLE) && |(cbus_ack_i & origin_mask);

  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d  = SNOOP;
          sticky_d = '0;
        end
      end
      SNOOP: begin
        // Origin acks are masked off; the last snoop ack moves on in the same edge.
        sticky_d = sticky_q | (cbus_ack_i & ~origin_mask);
        if (&(sticky_d | origin_mask)) state_d = ENABLE;
      end
      ENABLE: begin
        if (pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CNT_W'(1);
    else if (!accept && pop) count_d = count_q - CNT_W'(1);
    ack_d = '0;
    if (accept) ack_d[winner] = 1'b1;
  end

  // Next-cycle output image. The head entry is stable whenever state_d is not
  // IDLE because a pop always returns the engine to IDLE.
  always_comb begin
    cbus_cmd_d  = '0;
    cbus_addr_d = '0;
    broad_id_d  = '0;
    if (state_d != IDLE) begin
      cbus_addr_d = fifo_addr_q[rd_ptr_q];
      broad_id_d  = fifo_id_q[rd_ptr_q];
      for (int j = 0; j < NUM_CPU; j++) begin
        if (origin_mask[j]) begin
          if (state_d == ENABLE)
            cbus_cmd_d[j*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = head_rd ? CBUS_EN_RD : CBUS_EN_WR;
        end else if (state_d == SNOOP && !sticky_d[j]) begin
          cbus_cmd_d[j*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = head_rd ? CBUS_RD_SNOOP : CBUS_WR_SNOOP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ack_q       <= '0;
      sticky_q    <= '0;
      cbus_cmd_q  <= '0;
      cbus_addr_q <= '0;
      broad_id_q  <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < BROAD_FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_rd_q[i]   <= 1'b0;
        fifo_cpu_q[i]  <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      ack_q       <= ack_d;
      cbus_cmd_q  <= cbus_cmd_d;
      cbus_addr_q <= cbus_addr_d;
      broad_id_q  <= broad_id_d;
      busy_q      <= (state_d != IDLE);
      if (accept) begin
        fifo_addr_q[wr_ptr_q] <= win_addr;
        fifo_rd_q[wr_ptr_q]   <= win_rd;
        fifo_cpu_q[wr_ptr_q]  <= winner;
        fifo_id_q[wr_ptr_q]   <= id_cnt_q;
        wr_ptr_q              <= wr_ptr_q + BROAD_FIFO_DEPTH_LOG2'(1);
        id_cnt_q              <= id_cnt_q + BROAD_ID_WIDTH'(1);
        ptr_q                 <= ptr_d;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + BROAD_FIFO_DEPTH_LOG2'(1);
    end
  end

  assign mbus_ack_o   = ack_q;
  assign cbus_cmd_o   = cbus_cmd_q;
  assign cbus_addr_o  = cbus_addr_q;
  assign broad_id_o   = broad_id_q;
  assign fifo_count_o = count_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/mesi_isc_nport.md
Name: mesi_isc_nport

Overview:
Parametrised N-CPU MESI intersection controller, the successor of the fixed 4-CPU ISC. It accepts broadcast requests from NUM_CPU main-bus ports through a round-robin arbiter and queues them in a broadcast FIFO. Each head entry is then run as a snoop phase to every non-originating CPU, followed by an enable phase to the originator. It sits between the CPU/cache main-bus ports and the coherence buses.

Parameters:
NUM_CPU, 4, number of CPU ports (2..16)
CPU_ID_WIDTH, 2, clog2(NUM_CPU)
ADDR_WIDTH, 32, address width
MBUS_CMD_WIDTH, 3, main-bus command width
CBUS_CMD_WIDTH, 3, coherence-bus command width
BROAD_ID_WIDTH, 5, broadcast sequence-id width
BROAD_FIFO_DEPTH, 4, broadcast FIFO entries (power of 2)
BROAD_FIFO_DEPTH_LOG2, 2, log2(BROAD_FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mbus_cmd_i  in  NUM_CPU*MBUS_CMD_WIDTH  per-CPU main-bus command; CPU i in slice i
mbus_addr_i  in  NUM_CPU*ADDR_WIDTH  per-CPU main-bus address
cbus_ack_i  in  NUM_CPU  per-CPU coherence-bus acknowledge
mbus_ack_o  out  NUM_CPU  per-CPU main-bus acknowledge pulse
cbus_addr_o  out  ADDR_WIDTH  coherence address, shared by all CPUs
cbus_cmd_o  out  NUM_CPU*CBUS_CMD_WIDTH  per-CPU coherence command
broad_id_o  out  BROAD_ID_WIDTH  id of the entry in service
fifo_count_o  out  BROAD_FIFO_DEPTH_LOG2+1  FIFO occupancy
busy_o  out  1  engine not in IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst clears all registers at once, including mid-transaction; in-flight and queued entries are discarded.
- Reset values: all outputs 0 (cbus_cmd all NOP); arbiter pointer 0; id counter 0; state IDLE.
- Encodings. MBUS: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4. CBUS: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4. Any other MBUS code, including WR and RD, is ignored and never acked.
- Requesting: CPU i requests while its cmd is WR_BROAD or RD_BROAD. It holds cmd/addr stable until it sees mbus_ack_o[i], and drives NOP in the cycle after the ack.
- Arbitration: at most one accept per clock. Round-robin starts at ptr; ptr moves to winner+1 mod NUM_CPU after each accept. A port whose mbus_ack_o is high this cycle is masked, so a held request cannot be accepted twice.
- Accept: occurs when a request exists and fifo_count < DEPTH, evaluated on registered count. No push is allowed while full, even if a pop happens in the same cycle.
- On accept at edge E: write {addr, type, cpu_id, id_cnt}; mbus_ack_o[winner]=1 for exactly the cycle after E; id_cnt increments and wraps modulo 2^BROAD_ID_WIDTH.
- FIFO: push and pop in the same cycle are allowed when not full; count is unchanged. Pointers wrap modulo DEPTH.
- Engine FSM states: IDLE, SNOOP, ENABLE.
  - IDLE -> SNOOP at the first edge where the FIFO is non-empty. The sticky ack mask is cleared on entry.
  - SNOOP: cbus_cmd[j] = WR_SNOOP or RD_SNOOP for every j != origin whose sticky ack bit is 0; otherwise NOP. The origin always gets NOP.
  - SNOOP: cbus_ack_i[j]=1 sets sticky[j], and cbus_cmd[j] drops to NOP the next cycle.
  - SNOOP -> ENABLE when all non-origin sticky bits are set; this may happen in the same edge as the last ack.
  - ENABLE: cbus_cmd[origin] = EN_WR or EN_RD; all others NOP.
  - ENABLE: on cbus_ack_i[origin], pop the FIFO and go to IDLE. A back-to-back entry starts SNOOP at the next edge.
- Ignored acks: acks in IDLE, acks from the origin during SNOOP, and acks from non-origins during ENABLE.
- Outputs while busy: cbus_addr_o and broad_id_o show the head entry in SNOOP and ENABLE; both are 0 in IDLE. busy_o = (state != IDLE).
- Output timing: all outputs are registered or decoded from registers only; there is no combinational path from input to output.

Test Plan:
- Single request: NUM_CPU=4, CPU2 RD_BROAD addr 0x1000 -> mbus_ack_o=0100 for 1 cycle. Then cbus_cmd = RD_SNOOP on CPUs 0, 1, 3 with NOP on CPU2, and cbus_addr_o=0x1000. Acks from 0, 1, 3 on different cycles -> each cmd drops to NOP individually. Then EN_RD on CPU2; ack -> IDLE, broad_id_o was 0.
- Round-robin: all 4 CPUs assert WR_BROAD together after reset -> acks in order CPU0, 1, 2, 3 on consecutive cycles; ids 0, 1, 2, 3.
- Full: DEPTH=4 with snoop acks withheld and 5 requests -> 4 acked, fifo_count_o=4, 5th unacked. After the first ENABLE ack pops, the 5th is acked on the next cycle.
- Ignored commands and acks: CPU1 drives WR=1 -> never acked. Origin acks during SNOOP -> no state change.
- Id wrap: 33 sequential transactions -> 33rd broad_id_o=0.
- Reset mid-SNOOP: rst asserted while cbus_cmd is active -> all outputs 0 asynchronously, fifo_count_o=0, busy_o=0.
